// File: rtl/fsb_ctl_pkg.sv
// Shared definitions for the FSB bus-cycle scheduler: FSM states, select
// priority and the IDLE dispatch decision.
package fsb_ctl_pkg;

  localparam int unsigned CW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM,
    S_ROM,
    S_IO,
    S_NOSEL,
    S_REFRESH,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ROM,
    SEL_IO,
    SEL_RAM,
    SEL_REF,
    SEL_NOSEL
  } sel_t;

  // ROM beats IO beats RAM; a pending refresh steals RAM from a CPU cycle
  function automatic sel_t dispatch(input logic bact, input logic romcs,
                                    input logic iocs, input logic ramcs,
                                    input logic refreq);
    if (bact && romcs)                 return SEL_ROM;
    else if (bact && iocs)             return SEL_IO;
    else if (bact && ramcs && !refreq) return SEL_RAM;
    else if (refreq)                   return SEL_REF;
    else if (bact)                     return SEL_NOSEL;
    else                               return SEL_NONE;
  endfunction

endpackage

// File: rtl/fsb_ws_counter.sv
// Loadable up/down counter shared by the wait-state and timeout paths.
module fsb_ws_counter
  import fsb_ctl_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned TC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (!rst_n)    count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= up ? count + CW'(1) : count - CW'(1);
  end

  assign zero = (count == '0);
  assign tc   = (count == CW'(TC));

endmodule

// File: rtl/fsb_ready_ctl.sv
// FSB bus-cycle scheduler: RAM/refresh arbitration, wait states, IO bridge
// handshake, Ready/BErr generation. All outputs registered.
module fsb_ready_ctl
  import fsb_ctl_pkg::*;
#(
  parameter int unsigned RAM_WS  = 2,
  parameter int unsigned ROM_WS  = 1,
  parameter int unsigned REF_LEN = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic FCLK,
  input  logic nRES,
  input  logic BACT,
  input  logic RAMCS,
  input  logic ROMCS,
  input  logic IOCS,
  input  logic RefReq,
  input  logic IOAck,
  output logic RAMGo,
  output logic RefAct,
  output logic IOReq,
  output logic Ready,
  output logic BErr
);

  state_t        state, state_nx;
  logic          ramgo_nx, refact_nx, ioreq_nx, ready_nx, berr_nx;
  logic          cnt_load, cnt_en, cnt_up, cnt_zero, cnt_tc;
  logic [CW-1:0] cnt_val, cnt;

  fsb_ws_counter #(.CW(CW), .TC(TIMEOUT)) u_cnt (
    .clk      (FCLK),
    .rst_n    (nRES),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .count    (cnt),
    .zero     (cnt_zero),
    .tc       (cnt_tc)
  );

  always_ff @(posedge FCLK) begin
    if (!nRES) begin
      state  <= S_IDLE;
      RAMGo  <= 1'b0;
      RefAct <= 1'b0;
      IOReq  <= 1'b0;
      Ready  <= 1'b0;
      BErr   <= 1'b0;
    end else begin
      state  <= state_nx;
      RAMGo  <= ramgo_nx;
      RefAct <= refact_nx;
      IOReq  <= ioreq_nx;
      Ready  <= ready_nx;
      BErr   <= berr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ramgo_nx  = RAMGo;
    refact_nx = RefAct;
    ioreq_nx  = IOReq;
    ready_nx  = Ready;
    berr_nx   = BErr;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;

    unique case (state)
      S_IDLE: begin
        ramgo_nx  = 1'b0;
        refact_nx = 1'b0;
        ioreq_nx  = 1'b0;
        ready_nx  = 1'b0;
        berr_nx   = 1'b0;
        cnt_load  = 1'b1;
        unique case (dispatch(BACT, ROMCS, IOCS, RAMCS, RefReq))
          SEL_ROM:   begin state_nx = S_ROM;     cnt_val = CW'(ROM_WS); end
          SEL_IO:    begin state_nx = S_IO;      ioreq_nx = 1'b1; end
          SEL_RAM:   begin state_nx = S_RAM;     ramgo_nx = 1'b1; cnt_val = CW'(RAM_WS); end
          SEL_REF:   begin state_nx = S_REFRESH; refact_nx = 1'b1; cnt_val = CW'(REF_LEN - 1); end
          SEL_NOSEL: state_nx = S_NOSEL;
          default:   cnt_load = 1'b0;
        endcase
      end
      S_RAM, S_ROM: begin
        if (!BACT) begin
          state_nx = S_IDLE;
          ramgo_nx = 1'b0;
        end else if (cnt_zero) begin
          state_nx = S_DONE;
          ramgo_nx = 1'b0;
          ready_nx = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_IO: begin
        // abort first, then IOAck ahead of timeout
        if (!BACT) begin
          state_nx = S_IDLE;
          ioreq_nx = 1'b0;
        end else if (IOAck) begin
          state_nx = S_DONE;
          ioreq_nx = 1'b0;
          ready_nx = 1'b1;
        end else if (cnt_tc) begin
          state_nx = S_DONE;
          ioreq_nx = 1'b0;
          berr_nx  = 1'b1;
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end
      end
      S_NOSEL: begin
        if (!BACT) begin
          state_nx = S_IDLE;
        end else if (cnt_tc) begin
          state_nx = S_DONE;
          berr_nx  = 1'b1;
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end
      end
      S_REFRESH: begin
        if (cnt_zero) begin
          state_nx  = S_IDLE;
          refact_nx = 1'b0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        if (!BACT) begin
          state_nx = S_IDLE;
          ready_nx = 1'b0;
          berr_nx  = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
